// File: rtl/snn_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snn_sched_pkg : shared types and helpers for snn_step_scheduler           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package snn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_DONE     = 2'd3
    } sched_state_t;

    // Pointer needs at least one bit even for a single requester.
    function automatic int rr_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_step_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snn_step_scheduler_if : requester-side event bus (valid/ready/addr/weight)|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface snn_step_scheduler_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 4,
    parameter int VMEM_WIDTH = 16
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*ADDR_W-1:0]     req_addr;
    logic [N_REQ*VMEM_WIDTH-1:0] req_weight;

    modport master (
        output req_valid,
        output req_addr,
        output req_weight,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_weight,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/snn_step_scheduler_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot arbiter, pointer moves to winner+1       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rr_arbiter
    import snn_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = rr_ptr_width(N)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic [N-1:0]  req,
    input  wire logic          advance,
    output logic      [N-1:0]  grant,
    output logic      [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr;

    always_comb begin : p_select
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/snn_step_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snn_step_scheduler : per-step event dispatch into a LIF layer, settle,   |
// | and output-spike capture. Optional SCHED_STATS_EN adds a lifetime count. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module snn_step_scheduler
    import snn_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int N_NEURON      = 16,
    parameter int ADDR_W        = 4,
    parameter int VMEM_WIDTH    = 16,
    parameter int MAX_EVENTS    = 64,
    parameter int SETTLE_CYCLES = 4,
    localparam int CNT_W        = $clog2(MAX_EVENTS + 1)
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         step_start,
    snn_step_scheduler_if.slave               req_bus,
    output logic        [N_NEURON-1:0]        nrn_spike_in,
    output logic signed [VMEM_WIDTH-1:0]      nrn_weight,
    input  wire logic   [N_NEURON-1:0]        nrn_spike_out,
    output logic        [N_NEURON-1:0]        spike_vec,
    output logic                              step_done,
    output logic                              busy,
    output logic        [CNT_W-1:0]           event_count,
    output logic        [31:0]                total_events
);

    localparam int PW    = rr_ptr_width(N_REQ);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    sched_state_t                  state;
    sched_state_t                  state_next;
    logic [SET_W-1:0]              settle_cnt;

    logic                          w_any_valid;
    logic                          w_cap;
    logic                          w_arb_en;
    logic [N_REQ-1:0]              w_arb_req;
    logic [N_REQ-1:0]              w_grant;
    logic [PW-1:0]                 w_grant_idx;
    logic                          w_accept;
    logic [ADDR_W-1:0]             w_sel_addr;
    logic signed [VMEM_WIDTH-1:0]  w_sel_weight;
    logic                          w_in_range;
    logic [N_NEURON-1:0]           w_issue_vec;

    assign w_any_valid = |req_bus.req_valid;
    assign w_cap       = (event_count == CNT_W'(MAX_EVENTS));
    assign w_arb_en    = (state == ST_DISPATCH) && !w_cap;
    assign w_arb_req   = req_bus.req_valid & {N_REQ{w_arb_en}};
    assign w_accept    = |w_arb_req;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_arb_req),
        .advance   (w_accept),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign req_bus.req_ready = w_grant;

    assign w_sel_addr   = req_bus.req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
    assign w_sel_weight = req_bus.req_weight[int'(w_grant_idx)*VMEM_WIDTH +: VMEM_WIDTH];
    assign w_in_range   = (int'(w_sel_addr) < N_NEURON);

    for (genvar n = 0; n < N_NEURON; n++) begin : g_issue
        assign w_issue_vec[n] = (int'(w_sel_addr) == n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : p_next
        state_next = state;
        step_done  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (step_start) begin
                    state_next = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (!w_any_valid || w_cap) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                step_done  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state != ST_SETTLE) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end
    end

    // Issue is registered off the handshake, so it completes even after DISPATCH exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrn_spike_in <= '0;
            nrn_weight   <= '0;
        end else begin
            nrn_spike_in <= '0;
            if (w_accept && w_in_range) begin
                nrn_spike_in <= w_issue_vec;
                nrn_weight   <= w_sel_weight;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_count <= '0;
            spike_vec   <= '0;
        end else if (state == ST_IDLE) begin
            if (step_start) begin
                event_count <= '0;
                spike_vec   <= '0;
            end
        end else begin
            spike_vec <= spike_vec | nrn_spike_out;
            if (w_accept) begin
                event_count <= event_count + CNT_W'(1);
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_events <= '0;
        end else if (w_accept && (total_events != 32'hFFFF_FFFF)) begin
            total_events <= total_events + 32'd1;
        end
    end
`else
    assign total_events = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_step_scheduler.sv
`default_nettype none
// Self-checking bench for snn_step_scheduler: directed scenarios plus
// randomized steps checked against a queue-based behavioural model.

module tb_snn_step_scheduler;

    localparam int NR   = 4;
    localparam int NN   = 16;
    localparam int AW   = 5;
    localparam int VW   = 16;
    localparam int MAXE = 8;
    localparam int SC   = 4;
    localparam int CW   = $clog2(MAXE + 1);
    localparam int QD   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 step_start = 1'b0;
    logic [NN-1:0]        nrn_spike_in;
    logic signed [VW-1:0] nrn_weight;
    logic [NN-1:0]        nrn_spike_out = '0;
    logic [NN-1:0]        spike_vec;
    logic                 step_done;
    logic                 busy;
    logic [CW-1:0]        event_count;
    logic [31:0]          total_events;

    snn_step_scheduler_if #(.N_REQ(NR), .ADDR_W(AW), .VMEM_WIDTH(VW)) bus ();

    snn_step_scheduler #(
        .N_REQ         (NR),
        .N_NEURON      (NN),
        .ADDR_W        (AW),
        .VMEM_WIDTH    (VW),
        .MAX_EVENTS    (MAXE),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .step_start    (step_start),
        .req_bus       (bus),
        .nrn_spike_in  (nrn_spike_in),
        .nrn_weight    (nrn_weight),
        .nrn_spike_out (nrn_spike_out),
        .spike_vec     (spike_vec),
        .step_done     (step_done),
        .busy          (busy),
        .event_count   (event_count),
        .total_events  (total_events)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-requester FIFOs of pending events plus pointer.
    logic [AW-1:0]   q_addr [NR][QD];
    logic [VW-1:0]   q_w    [NR][QD];
    int              q_head [NR];
    int              q_cnt  [NR];
    int              ptr_m;
    logic [VW-1:0]   last_w;
    int unsigned     total_m;
    logic [NN-1:0]   held_vec;
    int              last_cnt;
    logic [NR-1:0]   grant_log [$];

    function automatic logic [31:0] exp_total();
`ifdef SCHED_STATS_EN
        return total_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [NN-1:0] spk_rand();
        logic [NN-1:0] v;
        v = '0;
        for (int b = 0; b < NN; b++) v[b] = ($urandom_range(0, 7) == 0);
        return v;
    endfunction

    task automatic push(input int i, input logic [AW-1:0] a, input logic [VW-1:0] w);
        q_addr[i][(q_head[i] + q_cnt[i]) % QD] = a;
        q_w[i][(q_head[i] + q_cnt[i]) % QD]    = w;
        q_cnt[i]++;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]           = (q_cnt[i] > 0);
            bus.req_addr[i*AW +: AW]   = q_addr[i][q_head[i]];
            bus.req_weight[i*VW +: VW] = q_w[i][q_head[i]];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            q_head[i] = 0;
            q_cnt[i]  = 0;
            for (int e = 0; e < QD; e++) begin
                q_addr[i][e] = '0;
                q_w[i][e]    = '0;
            end
        end
        ptr_m    = 0;
        last_w   = '0;
        total_m  = 0;
        held_vec = '0;
        last_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.req_ready !== 4'b0) begin
            errors++; $error("FAIL %s_ready: observed %0h expected 0", tag, bus.req_ready);
        end
        checks++;
        if (nrn_spike_in !== 16'h0) begin
            errors++; $error("FAIL %s_spike_in: observed %0h expected 0", tag, nrn_spike_in);
        end
        checks++;
        if (nrn_weight !== 16'sh0) begin
            errors++; $error("FAIL %s_weight: observed %0h expected 0", tag, nrn_weight);
        end
        checks++;
        if (spike_vec !== 16'h0) begin
            errors++; $error("FAIL %s_vec: observed %0h expected 0", tag, spike_vec);
        end
        checks++;
        if (step_done !== 1'b0) begin
            errors++; $error("FAIL %s_done: observed %0h expected 0", tag, step_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $error("FAIL %s_busy: observed %0h expected 0", tag, busy);
        end
        checks++;
        if (event_count !== 4'h0) begin
            errors++; $error("FAIL %s_count: observed %0h expected 0", tag, event_count);
        end
        checks++;
        if (total_events !== 32'h0) begin
            errors++; $error("FAIL %s_total: observed %0h expected 0", tag, total_events);
        end
    endtask

    // One full step, entered and left one ns after a rising edge in IDLE.
    task automatic run_step(input bit rand_spk, input bit poke);
        logic [NN-1:0] acc, exp_issue, so;
        logic [NR-1:0] exp_rdy;
        logic [AW-1:0] a;
        logic [31:0]   et;
        int cnt, win, i;
        drive_reqs();
        nrn_spike_out = '0;
        step_start    = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $error("FAIL idle_busy: observed %0h expected 0", busy);
        end
        checks++;
        if (bus.req_ready !== 4'b0) begin
            errors++; $error("FAIL idle_ready: observed %0h expected 0", bus.req_ready);
        end
        checks++;
        if (spike_vec !== held_vec) begin
            errors++; $error("FAIL idle_vec_held: observed %0h expected %0h", spike_vec, held_vec);
        end
        checks++;
        if (event_count !== CW'(last_cnt)) begin
            errors++; $error("FAIL idle_count_held: observed %0h expected %0h", event_count, last_cnt);
        end
        @(posedge clk); #1;
        step_start = 1'b0;
        acc = '0; cnt = 0; exp_issue = '0;
        grant_log.delete();
        for (int c = 0; c < MAXE + 2; c++) begin
            so = rand_spk ? spk_rand() : 16'h0200;
            nrn_spike_out = so;
            drive_reqs();
            win = -1;
            if (cnt < MAXE) begin
                for (int k = 0; k < NR; k++) begin
                    i = (ptr_m + k) % NR;
                    if (q_cnt[i] > 0) begin
                        win = i;
                        break;
                    end
                end
            end
            exp_rdy = (win >= 0) ? NR'(1 << win) : '0;
            et = exp_total();
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++; $error("FAIL disp_busy: observed %0h expected 1", busy);
            end
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++; $error("FAIL disp_ready: observed %0h expected %0h", bus.req_ready, exp_rdy);
            end
            checks++;
            if (event_count !== CW'(cnt)) begin
                errors++; $error("FAIL disp_count: observed %0h expected %0h", event_count, cnt);
            end
            checks++;
            if (nrn_spike_in !== exp_issue) begin
                errors++; $error("FAIL disp_spike_in: observed %0h expected %0h", nrn_spike_in, exp_issue);
            end
            checks++;
            if (nrn_weight !== last_w) begin
                errors++; $error("FAIL disp_weight: observed %0h expected %0h", nrn_weight, last_w);
            end
            checks++;
            if (spike_vec !== acc) begin
                errors++; $error("FAIL disp_vec: observed %0h expected %0h", spike_vec, acc);
            end
            checks++;
            if (step_done !== 1'b0) begin
                errors++; $error("FAIL disp_done: observed %0h expected 0", step_done);
            end
            checks++;
            if (total_events !== et) begin
                errors++; $error("FAIL disp_total: observed %0h expected %0h", total_events, et);
            end
            if (bus.req_ready != '0) grant_log.push_back(bus.req_ready);
            @(posedge clk);
            acc |= so;
            exp_issue = '0;
            if (win >= 0) begin
                a = q_addr[win][q_head[win]];
                if (int'(a) < NN) begin
                    exp_issue = NN'(1) << a;
                    last_w    = q_w[win][q_head[win]];
                end
                q_head[win] = (q_head[win] + 1) % QD;
                q_cnt[win]--;
                cnt++;
                total_m++;
                ptr_m = (win + 1) % NR;
            end
            #1;
            if (win < 0) break;
        end
        for (int s = 0; s < SC; s++) begin
            so = rand_spk ? spk_rand() : 16'h0020;
            nrn_spike_out = so;
            drive_reqs();
            step_start = poke && (s == 1);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++; $error("FAIL settle_busy: observed %0h expected 1", busy);
            end
            checks++;
            if (bus.req_ready !== 4'b0) begin
                errors++; $error("FAIL settle_ready: observed %0h expected 0", bus.req_ready);
            end
            checks++;
            if (step_done !== 1'b0) begin
                errors++; $error("FAIL settle_done: observed %0h expected 0", step_done);
            end
            checks++;
            if (nrn_spike_in !== exp_issue) begin
                errors++; $error("FAIL settle_spike_in: observed %0h expected %0h", nrn_spike_in, exp_issue);
            end
            checks++;
            if (nrn_weight !== last_w) begin
                errors++; $error("FAIL settle_weight: observed %0h expected %0h", nrn_weight, last_w);
            end
            checks++;
            if (event_count !== CW'(cnt)) begin
                errors++; $error("FAIL settle_count: observed %0h expected %0h", event_count, cnt);
            end
            checks++;
            if (spike_vec !== acc) begin
                errors++; $error("FAIL settle_vec: observed %0h expected %0h", spike_vec, acc);
            end
            @(posedge clk);
            acc |= so;
            exp_issue = '0;
            #1;
            step_start = 1'b0;
        end
        so = rand_spk ? spk_rand() : '0;
        nrn_spike_out = so;
        @(negedge clk);
        checks++;
        if (step_done !== 1'b1) begin
            errors++; $error("FAIL done_pulse: observed %0h expected 1", step_done);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $error("FAIL done_busy: observed %0h expected 1", busy);
        end
        checks++;
        if (spike_vec !== acc) begin
            errors++; $error("FAIL done_vec: observed %0h expected %0h", spike_vec, acc);
        end
        checks++;
        if (nrn_spike_in !== 16'h0) begin
            errors++; $error("FAIL done_spike_in: observed %0h expected 0", nrn_spike_in);
        end
        checks++;
        if (event_count !== CW'(cnt)) begin
            errors++; $error("FAIL done_count: observed %0h expected %0h", event_count, cnt);
        end
        @(posedge clk);
        acc |= so;
        #1;
        nrn_spike_out = '0;
        for (int j = 0; j < 2; j++) begin
            et = exp_total();
            @(negedge clk);
            checks++;
            if (step_done !== 1'b0) begin
                errors++; $error("FAIL post_done: observed %0h expected 0", step_done);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $error("FAIL post_busy: observed %0h expected 0", busy);
            end
            checks++;
            if (spike_vec !== acc) begin
                errors++; $error("FAIL post_vec: observed %0h expected %0h", spike_vec, acc);
            end
            checks++;
            if (event_count !== CW'(cnt)) begin
                errors++; $error("FAIL post_count: observed %0h expected %0h", event_count, cnt);
            end
            checks++;
            if (bus.req_ready !== 4'b0) begin
                errors++; $error("FAIL post_ready: observed %0h expected 0", bus.req_ready);
            end
            checks++;
            if (total_events !== et) begin
                errors++; $error("FAIL post_total: observed %0h expected %0h", total_events, et);
            end
            @(posedge clk); #1;
        end
        held_vec = acc;
        last_cnt = cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        drive_reqs();
        #1 rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Round robin: two events per requester, order must be 0,1,2,3,0,1,2,3.
        for (int i = 0; i < NR; i++)
            for (int e = 0; e < 2; e++)
                push(i, AW'($urandom_range(0, NN - 1)), VW'($urandom));
        run_step(1'b1, 1'b0);
        checks++;
        if (grant_log.size() !== 8) begin
            errors++; $error("FAIL rr_grants: observed %0d expected 8", grant_log.size());
        end
        for (int n = 0; n < grant_log.size(); n++) begin
            checks++;
            if (grant_log[n] !== NR'(1 << (n % NR))) begin
                errors++; $error("FAIL rr_order: observed %0h expected %0h", grant_log[n], NR'(1 << (n % NR)));
            end
        end

        // Single requester with addr 3, weight 500; pointer restarted at 0.
        push(0, 5'd3, 16'd500);
        run_step(1'b1, 1'b0);
        checks++;
        if (event_count !== 4'd1) begin
            errors++; $error("FAIL single_count: observed %0h expected 1", event_count);
        end
        checks++;
        if (nrn_weight !== 16'sd500) begin
            errors++; $error("FAIL single_weight: observed %0h expected %0h", nrn_weight, 16'sd500);
        end

        // Event cap: 12 pending, exactly MAXE accepted, the rest stay pending.
        for (int i = 0; i < NR; i++)
            for (int e = 0; e < 3; e++)
                push(i, AW'($urandom_range(0, NN - 1)), VW'($urandom));
        run_step(1'b1, 1'b1);
        checks++;
        if (event_count !== 4'd8) begin
            errors++; $error("FAIL cap_count: observed %0h expected 8", event_count);
        end
        checks++;
        if (bus.req_ready !== 4'b0) begin
            errors++; $error("FAIL cap_pending_ready: observed %0h expected 0", bus.req_ready);
        end
        run_step(1'b1, 1'b0);
        checks++;
        if (event_count !== 4'd4) begin
            errors++; $error("FAIL drain_count: observed %0h expected 4", event_count);
        end

        // Out-of-range address: counted, no spike, weight holds.
        push(1, 5'd20, 16'h7ABC);
        run_step(1'b1, 1'b0);
        checks++;
        if (event_count !== 4'd1) begin
            errors++; $error("FAIL oor_count: observed %0h expected 1", event_count);
        end

        // Spike capture: bit 9 during DISPATCH, bit 5 during SETTLE.
        push(2, 5'd7, 16'hFF00);
        push(3, 5'd1, 16'h0042);
        run_step(1'b0, 1'b1);
        checks++;
        if (spike_vec !== 16'h0220) begin
            errors++; $error("FAIL capture_vec: observed %0h expected 0220", spike_vec);
        end

        // Reset mid-DISPATCH drops everything, including the in-flight issue.
        push(2, 5'd4, 16'h1234);
        push(2, 5'd6, 16'h5678);
        push(2, 5'd8, 16'h9ABC);
        drive_reqs();
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $error("FAIL pre_rst_busy: observed %0h expected 1", busy);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midstep_rst");
        model_reset();
        drive_reqs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized steps.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NR; i++) begin
                int n_add;
                n_add = $urandom_range(0, 4);
                for (int e = 0; e < n_add; e++) begin
                    if (q_cnt[i] < 12) begin
                        if ($urandom_range(0, 3) == 0)
                            push(i, AW'($urandom_range(NN, 31)), VW'($urandom));
                        else
                            push(i, AW'($urandom_range(0, NN - 1)), VW'($urandom));
                    end
                end
            end
            run_step(1'b1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
